piso_serializer: RTL and testbench

- Single-clock parallel-in/serial-out converter.
- Accepts DATA_W-bit words over a valid/ready handshake and buffers them in an internal synchronous FIFO.
- Shifts each word out one bit per accepted serial beat, MSB first, over a second valid/ready handshake.
- Sits between a byte-wide producer and a bit-serial link or consumer.

---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_serializer_if.sv | 32 +++
 rtl/piso_serializer_sync_fifo.sv | 63 ++++++
 rtl/piso_serializer.sv | 97 +++++++++
 tb/tb_piso_serializer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared definitions for the parallel-in/serial-out serializer:
//     - default word width and FIFO depth
//     - FSM state type and its one-hot encodings
// ---------------------------------------------------------------------------
package piso_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_FIFO_EMPTY        = 3'b001;
  localparam state_t S_RD_FIFO           = 3'b010;
  localparam state_t S_DRIVE_SERIAL_INTF = 3'b100;

endpackage

// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//   Both handshakes of the serializer in one bundle.
//     data_i/valid_i/ready_o : parallel word side (producer -> block)
//     data_o/valid_o/ready_i : serial bit side   (block -> consumer)
//   Handshake rule (both sides): a transfer happens at a rising edge where
//   valid and ready are both high. A source keeps valid and its data stable
//   until the transfer happens; ready never depends on valid.
//   Modports: slave = the serializer, master = whatever drives it.
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int DATA_W = piso_pkg::DEF_DATA_W
) ();

  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              data_o;
  logic              valid_o;
  logic              ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

endinterface

// File: rtl/piso_serializer_sync_fifo.sv
// ---------------------------------------------------------------------------
// piso_sync_fifo
//   Single-clock FIFO with show-ahead read (rd_data is the head word).
//   Ports:
//     pclk_i, rst_i       clock, asynchronous active-low reset
//     wr_en, wr_data      push (ignored while full)
//     rd_en, rd_data      pop  (ignored while empty), head word
//     full, empty         derived from the registered occupancy count
// ---------------------------------------------------------------------------
module piso_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              pclk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Gate internally so a misbehaving caller can never corrupt the count.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Depth is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge pclk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only pointers/count define validity.
  always_ff @(posedge pclk_i) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Buffers DATA_W-bit words in a FIFO and shifts each one out MSB first,
//   one bit per accepted serial beat.
//   Ports:
//     pclk_i   clock (rising edge)
//     rst_i    asynchronous active-low reset
//     bus      piso_serializer_if.slave (parallel in / serial out handshakes)
//     state_o  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                    pclk_i,
  input  logic                    rst_i,
  piso_serializer_if.slave        bus,
  output state_t                  state_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              run_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              wr_en;
  logic              rd_en;
  logic              beat;

  // run_q holds ready_o low through reset and rises on the first edge after
  // release, independent of the FIFO's own full flag.
  assign bus.ready_o = run_q && !fifo_full;
  assign wr_en       = bus.valid_i && bus.ready_o;
  assign rd_en       = (state_q == S_RD_FIFO);
  assign beat        = (state_q == S_DRIVE_SERIAL_INTF) && bus.ready_i;

  assign bus.valid_o = (state_q == S_DRIVE_SERIAL_INTF);
  assign bus.data_o  = (state_q == S_DRIVE_SERIAL_INTF) ? shreg_q[DATA_W-1] : 1'b0;
  assign state_o     = state_q;

  piso_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .pclk_i  (pclk_i),
    .rst_i   (rst_i),
    .wr_en   (wr_en),
    .wr_data (bus.data_i),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge pclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_FIFO_EMPTY;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      run_q     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_FIFO_EMPTY: begin
          if (!fifo_empty) state_q <= S_RD_FIFO;
        end
        S_RD_FIFO: begin
          shreg_q   <= fifo_rd_data;
          bit_cnt_q <= '0;
          state_q   <= S_DRIVE_SERIAL_INTF;
        end
        S_DRIVE_SERIAL_INTF: begin
          if (beat) begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            // Last beat: go straight to the next word if one is waiting.
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= fifo_empty ? S_FIFO_EMPTY : S_RD_FIFO;
            end
          end
        end
        default: state_q <= S_FIFO_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer: reset, single word, back-pressure,
//   full FIFO, random stream, reset mid-word.
// ---------------------------------------------------------------------------
module tb_piso_serializer;
  import piso_pkg::*;

  logic   pclk_i;
  logic   rst_i;
  state_t state_o;

  piso_serializer_if #(.DATA_W(8)) bus ();

  piso_serializer #(
    .DATA_W     (8),
    .FIFO_DEPTH (16)
  ) dut (
    .pclk_i  (pclk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (state_o)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  initial begin
    pclk_i = 1'b0;
    forever #5 pclk_i = ~pclk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.data_i  = 'x;
  endtask

  // Collect n words from the serial side with ready_i high and compare each
  // reconstructed word against the expected queue.
  task automatic drain(input int n_words, input bit check_bubble);
    logic [7:0] acc;
    logic [7:0] exp;
    int bits;
    int got;
    int cyc;
    acc = '0;
    bits = 0;
    got = 0;
    cyc = 0;
    bus.ready_i = 1'b1;
    while (got < n_words && cyc < 2000) begin
      if (bus.valid_o) begin
        acc = {acc[6:0], bus.data_o};
        bits++;
        if (bits == 8) begin
          exp = 'x;
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          check("drain_word", 32'(acc), 32'(exp));
          bits = 0;
          got++;
          tick();
          cyc++;
          if (check_bubble) check("drain_bubble", 32'(bus.valid_o), 32'd0);
          continue;
        end
      end
      tick();
      cyc++;
    end
    check("drain_count", 32'(got), 32'(n_words));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] w;
    logic [7:0] acc;
    logic [7:0] exp;
    int b;
    int seen;

    rst_i       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    check("rst_ready_o", 32'(bus.ready_o), 32'd0);
    check("rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("rst_data_o",  32'(bus.data_o),  32'd0);
    check("rst_state",   32'(state_o),     32'(S_FIFO_EMPTY));
    rst_i = 1'b1;
    tick();
    check("post_rst_ready_o", 32'(bus.ready_o), 32'd1);
    check("post_rst_state",   32'(state_o),     32'(S_FIFO_EMPTY));

    // Single word 8'hA5 with ready_i high: valid_o after edge N+2.
    bus.ready_i = 1'b1;
    w = 8'hA5;
    write_word(w);
    check("lat_n0_valid", 32'(bus.valid_o), 32'd0);
    tick();
    check("lat_n1_valid", 32'(bus.valid_o), 32'd0);
    check("lat_n1_state", 32'(state_o),     32'(S_RD_FIFO));
    tick();
    for (int i = 0; i < 8; i++) begin
      check("a5_valid", 32'(bus.valid_o), 32'd1);
      check("a5_bit",   32'(bus.data_o),  32'(w[7-i]));
      tick();
    end
    check("a5_end_valid", 32'(bus.valid_o), 32'd0);
    check("a5_end_data",  32'(bus.data_o),  32'd0);
    check("a5_end_state", 32'(state_o),     32'(S_FIFO_EMPTY));

    // Back-pressure on 8'h3C: 2 beats, 5 stalled cycles, then the rest.
    w = 8'h3C;
    write_word(w);
    tick();
    tick();
    b = 0;
    for (int c = 0; c < 13; c++) begin
      check("bp_valid", 32'(bus.valid_o), 32'd1);
      check("bp_bit",   32'(bus.data_o),  32'(w[7-b]));
      bus.ready_i = (c < 2 || c >= 7);
      tick();
      if (bus.ready_i) b++;
    end
    check("bp_end_valid", 32'(bus.valid_o), 32'd0);

    // Full FIFO: the first word lands in the shift register, 16 more fill it.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check("full_ready_before", 32'(bus.ready_o), 32'd1);
      exp_q.push_back(8'(8'h40 + i));
      write_word(8'(8'h40 + i));
    end
    check("full_ready_o", 32'(bus.ready_o), 32'd0);
    bus.data_i  = 8'hEE;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.data_i  = 'x;
    check("full_reject_ready", 32'(bus.ready_o), 32'd0);
    check("full_state",        32'(state_o),     32'(S_DRIVE_SERIAL_INTF));
    bus.ready_i = 1'b1;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc = {acc[6:0], bus.data_o};
      check("full_hold_ready", 32'(bus.ready_o), 32'd0);
      tick();
    end
    exp = exp_q.pop_front();
    check("full_word0", 32'(acc), 32'(exp));
    check("full_rd_state", 32'(state_o),     32'(S_RD_FIFO));
    check("full_rd_ready", 32'(bus.ready_o), 32'd0);
    tick();
    check("full_pop_ready", 32'(bus.ready_o), 32'd1);
    check("full_pop_valid", 32'(bus.valid_o), 32'd1);
    drain(16, 1'b1);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);
    seen = 0;
    repeat (12) begin
      if (bus.valid_o) seen++;
      tick();
    end
    check("full_no_extra_word", 32'(seen), 32'd0);

    // Stream of 10 random bytes.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      write_word(w);
    end
    drain(10, 1'b1);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-word: 8'hFF in flight with 2 words queued.
    bus.ready_i = 1'b0;
    write_word(8'hFF);
    write_word(8'h12);
    write_word(8'h34);
    check("mid_valid_before", 32'(bus.valid_o), 32'd1);
    bus.ready_i = 1'b1;
    repeat (3) tick();
    check("mid_data_before", 32'(bus.data_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_data",  32'(bus.data_o),  32'd0);
    check("mid_rst_ready", 32'(bus.ready_o), 32'd0);
    tick();
    tick();
    rst_i = 1'b1;
    seen = 0;
    repeat (20) begin
      if (bus.valid_o) seen++;
      tick();
    end
    check("mid_idle_after_rst", 32'(seen), 32'd0);
    check("mid_ready_after_rst", 32'(bus.ready_o), 32'd1);
    exp_q.push_back(8'h5A);
    write_word(8'h5A);
    drain(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
